frame_transmitter: RTL and testbench
====================================

Name: frame_transmitter

Overview:
Loop-timed SONET-style frame transmitter feeding the XRT91L31 transmit byte interface; the transmit direction of the framer.
- Host loads a payload buffer as 16-bit words, then pulses go.
- Block emits a 2-byte framing header (A1, A2), then FRAME_LENGTH payload bytes, then idle fill.
- Runs entirely on the recovered clock rxclk (loop timing); the host-side logic driving it is synchronous to rxclk.

Parameters:
FRAME_LENGTH, 16, payload bytes per frame; even, 2..256
HDR_A1, 8'hF6, first framing byte
HDR_A2, 8'h28, second framing byte
IDLE_BYTE, 8'h00, byte driven on txd when not transmitting

Ports:
rst  input  1  asynchronous, active-high reset
rxclk  input  1  recovered clock from XRT91L31, used as transmit clock
wr_en  input  1  payload word write strobe
wr_addr  input  8  word address; covers bytes 2*wr_addr and 2*wr_addr+1
wr_data  input  16  [15:8] -> byte 2*wr_addr, [7:0] -> byte 2*wr_addr+1
wr_reject  output  1  one-cycle pulse: last write ignored (busy or out of range)
go  input  1  request to transmit one frame
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when last payload byte has been sent
txd  output  8  transmit byte to XRT91L31, registered
tx_frame_begin  output  1  high with the A1 byte only
tx_valid  output  1  high for header and payload bytes

Behaviour:
- Reset: rst is asynchronous, active-high; clock is rxclk.
  - State IDLE; txd=IDLE_BYTE; busy, frame_done, tx_frame_begin, tx_valid, wr_reject all 0; byte counter 0.
  - Payload RAM is not reset.
- Write port:
  - Sampled at rxclk edge when wr_en=1.
  - Accepted only if state==IDLE and 2*wr_addr+1 < FRAME_LENGTH; then both bytes are written at that edge.
  - Otherwise RAM is unchanged and wr_reject=1 for the following cycle.
  - A write accepted in the same edge as go lands in the frame.
- State machine: IDLE -> HDR1 -> HDR2 -> PAYLOAD -> IDLE. All outputs are registered.
  - IDLE, go=1 at edge k: after edge k, state HDR1, txd=HDR_A1, tx_frame_begin=1, tx_valid=1, busy=1. Counter cleared.
  - HDR1 at edge k+1 -> HDR2: txd=HDR_A2, tx_frame_begin=0.
  - HDR2 at edge k+2 -> PAYLOAD: txd=byte[0].
  - PAYLOAD: each edge outputs byte[counter+1] and increments the counter.
  - After edge k+1+FRAME_LENGTH, txd=byte[FRAME_LENGTH-1].
  - Next edge (counter==FRAME_LENGTH-1) -> IDLE: txd=IDLE_BYTE, tx_valid=0, busy=0, frame_done=1 for one cycle.
- Timing: busy is high exactly FRAME_LENGTH+2 cycles. tx_valid is coincident with busy.
- go rules:
  - go while busy is ignored; no queuing.
  - go high in the cycle frame_done is high (state IDLE) is accepted, giving back-to-back frames separated by exactly one IDLE_BYTE.
  - go held high continuously repeats frames with one idle byte between them.
- Counter width: 9 bits, so FRAME_LENGTH=256 is supported. Reads index byte[counter] only; no wrap.
- Reset mid-frame: immediate return to reset state; no frame_done; the next go restarts from A1.

Optional Feature:
- Macro FRAME_TX_SCRAMBLE_EN.
- Defined:
  - Payload bytes (not A1/A2, not idle) are XORed with a frame-synchronous x^7+x^6+1 scrambler.
  - Scrambler is preset to 7'h7F on the A2 byte and steps 8 bits per payload byte, MSB first.
  - With an all-zero payload, bytes 0,1 are 8'hFE, 8'h04.
- Undefined: payload transmitted raw; no scrambler logic present.

Test Plan:
1. Reset, write words 0..7 with 16'h0102..16'h0F10 (pattern {2a+1,2a+2}), go pulse -> txd sequence F6,28,01,02,...,10 then 00; tx_frame_begin only on F6; busy high 18 cycles; frame_done single pulse as busy falls.
2. go held high for 40 cycles -> frames repeat with exactly one 00 between last payload byte and next F6; writes during busy -> wr_reject pulse, payload unchanged in the next frame.
3. Write with wr_addr=8 (FRAME_LENGTH=16) while IDLE -> wr_reject=1 next cycle; transmitted frame unchanged.
4. Assert rst at payload byte 5 -> all outputs at reset values immediately, no frame_done; next go yields a full correct frame starting F6.
5. FRAME_LENGTH=256, all payload written, go -> 258 busy cycles, byte 255 correct, no counter overflow.
6. FRAME_TX_SCRAMBLE_EN defined, zero payload -> payload starts FE,04; header bytes F6,28 unscrambled.

Source files
------------

// File: rtl/frame_transmitter.sv
// Loop-timed framed byte transmitter: A1/A2 header, payload buffer, idle fill.
// Optional payload scrambler (x^7+x^6+1) enabled by defining FRAME_TX_SCRAMBLE_EN.
//
// Ports:
//   rst            async active-high reset
//   rxclk          recovered clock, used as transmit clock
//   wr_en          payload word write strobe
//   wr_addr        word address (bytes 2*wr_addr, 2*wr_addr+1)
//   wr_data        [15:8] even byte, [7:0] odd byte
//   wr_reject      pulse: previous-edge write ignored
//   go             request one frame
//   busy           frame in progress
//   frame_done     pulse after last payload byte
//   txd            registered transmit byte
//   tx_frame_begin high with A1 only
//   tx_valid       high for header and payload bytes
module frame_transmitter #(
   parameter int          FRAME_LENGTH = 16,
   parameter logic [7:0]  HDR_A1       = 8'hF6,
   parameter logic [7:0]  HDR_A2       = 8'h28,
   parameter logic [7:0]  IDLE_BYTE    = 8'h00
) (
   input  logic        rst,
   input  logic        rxclk,
   input  logic        wr_en,
   input  logic [7:0]  wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_reject,
   input  logic        go,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  txd,
   output logic        tx_frame_begin,
   output logic        tx_valid
);

   localparam int AW = (FRAME_LENGTH > 2) ? $clog2(FRAME_LENGTH) : 1;
   localparam logic [8:0] LAST = 9'(FRAME_LENGTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR1,
      S_HDR2,
      S_PAY
   } state_t;

   state_t      state_q;
   logic [8:0]  cnt_q;
   logic [8:0]  cnt_d;
   logic [7:0]  txd_q;
   logic        busy_q;
   logic        valid_q;
   logic        begin_q;
   logic        done_q;
   logic        rej_q;

   logic [7:0]  mem [FRAME_LENGTH];
   logic        wr_ok;
   logic [AW-1:0] rd_idx;
   logic [7:0]  rd_byte;
   logic [7:0]  pay_out;

   // Highest byte of the word must still lie inside the frame.
   assign wr_ok = wr_en && (state_q == S_IDLE)
                  && ({1'b0, wr_addr, 1'b1} < 10'(FRAME_LENGTH));

   always_ff @(posedge rxclk) begin
      if (wr_ok) begin
         mem[AW'({wr_addr, 1'b0})] <= wr_data[15:8];
         mem[AW'({wr_addr, 1'b1})] <= wr_data[7:0];
      end
   end

   assign cnt_d   = cnt_q + 9'd1;
   // HDR2 fetches byte 0; PAYLOAD fetches the byte after the current one.
   assign rd_idx  = (state_q == S_HDR2) ? '0 : AW'(cnt_d);
   assign rd_byte = mem[rd_idx];

`ifdef FRAME_TX_SCRAMBLE_EN
   logic [6:0]  scr_q;
   logic [6:0]  scr_d;
   logic [7:0]  scr_mask;

   // Eight serial steps, MSB first: out = s[6], feedback = s[6]^s[5].
   always_comb begin
      scr_d    = scr_q;
      scr_mask = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         scr_mask[i] = scr_d[6];
         scr_d       = {scr_d[5:0], scr_d[6] ^ scr_d[5]};
      end
   end

   assign pay_out = rd_byte ^ scr_mask;

   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         scr_q <= 7'h7F;
      end else begin
         unique case (state_q)
            S_HDR1:  scr_q <= 7'h7F;
            S_HDR2:  scr_q <= scr_d;
            S_PAY:   if (cnt_q != LAST) scr_q <= scr_d;
            default: scr_q <= scr_q;
         endcase
      end
   end
`else
   assign pay_out = rd_byte;
`endif

   always_ff @(posedge rxclk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         txd_q   <= IDLE_BYTE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         begin_q <= 1'b0;
         done_q  <= 1'b0;
         rej_q   <= 1'b0;
      end else begin
         rej_q   <= wr_en && !wr_ok;
         done_q  <= 1'b0;
         begin_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (go) begin
                  state_q <= S_HDR1;
                  cnt_q   <= '0;
                  txd_q   <= HDR_A1;
                  begin_q <= 1'b1;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end else begin
                  txd_q   <= IDLE_BYTE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            S_HDR1: begin
               state_q <= S_HDR2;
               txd_q   <= HDR_A2;
            end
            S_HDR2: begin
               state_q <= S_PAY;
               cnt_q   <= '0;
               txd_q   <= pay_out;
            end
            S_PAY: begin
               if (cnt_q == LAST) begin
                  state_q <= S_IDLE;
                  txd_q   <= IDLE_BYTE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_d;
                  txd_q   <= pay_out;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign txd            = txd_q;
   assign busy           = busy_q;
   assign tx_valid       = valid_q;
   assign tx_frame_begin = begin_q;
   assign frame_done     = done_q;
   assign wr_reject      = rej_q;

endmodule

// File: tb/tb_frame_transmitter.sv
// Bench for frame_transmitter: table-driven cycle vectors on a 16-byte
// instance plus hand sequences for reset mid-frame and a 256-byte instance.
module tb_frame_transmitter;

   logic        rxclk = 1'b0;
   logic        rst   = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        go = 1'b0;
   logic        wr_reject, busy, frame_done, tx_frame_begin, tx_valid;
   logic [7:0]  txd;

   logic        b_wr_en = 1'b0;
   logic [7:0]  b_wr_addr = '0;
   logic [15:0] b_wr_data = '0;
   logic        b_go = 1'b0;
   logic        b_wr_reject, b_busy, b_frame_done, b_begin, b_valid;
   logic [7:0]  b_txd;

   always #5 rxclk = ~rxclk;

   frame_transmitter #(.FRAME_LENGTH(16)) dut (
      .rst(rst), .rxclk(rxclk), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_reject(wr_reject), .go(go), .busy(busy),
      .frame_done(frame_done), .txd(txd),
      .tx_frame_begin(tx_frame_begin), .tx_valid(tx_valid)
   );

   frame_transmitter #(.FRAME_LENGTH(256)) dut_big (
      .rst(rst), .rxclk(rxclk), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .wr_reject(b_wr_reject), .go(b_go),
      .busy(b_busy), .frame_done(b_frame_done), .txd(b_txd),
      .tx_frame_begin(b_begin), .tx_valid(b_valid)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] pay_m [16];
   logic [7:0] big_m [256];

   typedef struct {
      logic        we;
      logic [7:0]  wa;
      logic [15:0] wd;
      logic        go;
      logic [7:0]  txd;
      logic        vld;
      logic        beg;
      logic        bsy;
      logic        done;
      logic        rej;
      string       tag;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference scrambler: sequence preset to all-ones, taps x^7+x^6+1.
   function automatic logic [7:0] scr_mask(input int j);
`ifdef FRAME_TX_SCRAMBLE_EN
      logic [6:0] s = 7'h7F;
      logic [7:0] o = 8'h00;
      for (int b = 0; b <= j; b++)
         for (int i = 7; i >= 0; i--) begin
            o[i] = s[6];
            s = {s[5:0], s[6] ^ s[5]};
         end
      return o;
`else
      return 8'h00 & 8'(j);
`endif
   endfunction

   task automatic push(input logic we, input logic [7:0] wa,
                       input logic [15:0] wd, input logic g,
                       input logic [7:0] t, input logic v, input logic b,
                       input logic bz, input logic d, input logic r,
                       input string tag);
      vec_t x;
      x.we = we; x.wa = wa; x.wd = wd; x.go = g;
      x.txd = t; x.vld = v; x.beg = b; x.bsy = bz;
      x.done = d; x.rej = r; x.tag = tag;
      tbl.push_back(x);
   endtask

   task automatic push_idle();
      push(0, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0, "idle");
   endtask

   // One full frame; wr_j >= 0 puts a busy-time write at payload slot wr_j.
   task automatic add_frame(input bit hold, input int wr_j);
      push(0, 8'h00, 16'h0000, 1, 8'hF6, 1, 1, 1, 0, 0, "a1");
      push(0, 8'h00, 16'h0000, hold, 8'h28, 1, 0, 1, 0, 0, "a2");
      for (int j = 0; j < 16; j++)
         push(j == wr_j, 8'h00, 16'hFFFF, hold,
              pay_m[j] ^ scr_mask(j), 1, 0, 1, 0, j == wr_j,
              $sformatf("p%0d", j));
      push(0, 8'h00, 16'h0000, hold, 8'h00, 0, 0, 0, 1, 0, "end");
   endtask

   task automatic run_table();
      foreach (tbl[i]) begin
         wr_en   = tbl[i].we;
         wr_addr = tbl[i].wa;
         wr_data = tbl[i].wd;
         go      = tbl[i].go;
         @(posedge rxclk);
         #1;
         chk({tbl[i].tag, "/txd"},  txd,            tbl[i].txd);
         chk({tbl[i].tag, "/vld"},  tx_valid,       tbl[i].vld);
         chk({tbl[i].tag, "/beg"},  tx_frame_begin, tbl[i].beg);
         chk({tbl[i].tag, "/busy"}, busy,           tbl[i].bsy);
         chk({tbl[i].tag, "/done"}, frame_done,     tbl[i].done);
         chk({tbl[i].tag, "/rej"},  wr_reject,      tbl[i].rej);
      end
      wr_en = 0;
      go    = 0;
      tbl.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int nb;
      bit ended;
      logic [7:0] last_b;

      repeat (2) @(posedge rxclk);
      #1;
      chk("rst/txd", txd, 8'h00);
      chk("rst/busy", busy, 1'b0);
      chk("rst/vld", tx_valid, 1'b0);
      chk("rst/beg", tx_frame_begin, 1'b0);
      chk("rst/done", frame_done, 1'b0);
      chk("rst/rej", wr_reject, 1'b0);
      chk("rst/big_busy", b_busy, 1'b0);
      rst = 0;

      // Basic frame with the incrementing pattern.
      for (int a = 0; a < 8; a++) begin
         pay_m[2*a]   = 8'(2*a + 1);
         pay_m[2*a+1] = 8'(2*a + 2);
         push(1, 8'(a), {8'(2*a + 1), 8'(2*a + 2)}, 0,
              8'h00, 0, 0, 0, 0, 0, "wr");
      end
      add_frame(0, -1);
      push_idle();
      run_table();

      // Out-of-range word write while idle.
      push(1, 8'h08, 16'hDEAD, 0, 8'h00, 0, 0, 0, 0, 1, "oor");
      push_idle();
      add_frame(0, -1);
      push_idle();
      run_table();

      // go held high: back-to-back frames, one idle byte between;
      // write during busy is rejected and does not alter later frames.
      add_frame(1, 3);
      add_frame(1, -1);
      add_frame(0, -1);
      push_idle();
      run_table();

      // Reset while payload byte 5 is on txd.
      go = 1;
      @(posedge rxclk);
      #1;
      go = 0;
      repeat (7) @(posedge rxclk);
      #1;
      chk("mid/pre_txd", txd, pay_m[5] ^ scr_mask(5));
      #2;
      rst = 1;
      #1;
      chk("mid/txd", txd, 8'h00);
      chk("mid/busy", busy, 1'b0);
      chk("mid/vld", tx_valid, 1'b0);
      chk("mid/done", frame_done, 1'b0);
      @(posedge rxclk);
      #1;
      rst = 0;
      chk("mid/done2", frame_done, 1'b0);
      @(posedge rxclk);
      #1;
      chk("mid/done3", frame_done, 1'b0);
      chk("mid/busy3", busy, 1'b0);
      add_frame(0, -1);
      push_idle();
      run_table();

      // 256-byte instance: full buffer, 258 busy cycles.
      for (int a = 0; a < 128; a++) begin
         big_m[2*a]   = 8'(2*a) ^ 8'hA5;
         big_m[2*a+1] = 8'(2*a + 1) ^ 8'hA5;
         b_wr_en   = 1;
         b_wr_addr = 8'(a);
         b_wr_data = {big_m[2*a], big_m[2*a+1]};
         @(posedge rxclk);
         #1;
      end
      chk("big/wr_rej", b_wr_reject, 1'b0);
      b_wr_en = 0;
      b_go = 1;
      @(posedge rxclk);
      #1;
      b_go = 0;
      nb = 0;
      ended = 0;
      last_b = 8'h00;
      for (int c = 0; c < 400 && !ended; c++) begin
         if (b_busy) begin
            nb++;
            if (nb == 1) chk("big/a1", b_txd, 8'hF6);
            if (nb >= 3 && nb <= 258) begin
               last_b = b_txd;
               if (b_txd !== (big_m[nb-3] ^ scr_mask(nb - 3)))
                  chk($sformatf("big/p%0d", nb - 3), b_txd,
                      big_m[nb-3] ^ scr_mask(nb - 3));
            end
            @(posedge rxclk);
            #1;
         end else begin
            ended = 1;
            chk("big/done", b_frame_done, 1'b1);
            chk("big/idle_txd", b_txd, 8'h00);
         end
      end
      chk("big/ended", ended, 1'b1);
      chk("big/busy_cycles", nb, 258);
      chk("big/b255", last_b, big_m[255] ^ scr_mask(255));
      @(posedge rxclk);
      #1;
      chk("big/done_pulse", b_frame_done, 1'b0);

`ifdef FRAME_TX_SCRAMBLE_EN
      // All-zero payload shows the raw scrambler sequence.
      for (int a = 0; a < 8; a++) begin
         wr_en   = 1;
         wr_addr = 8'(a);
         wr_data = 16'h0000;
         @(posedge rxclk);
         #1;
      end
      wr_en = 0;
      go = 1;
      @(posedge rxclk);
      #1;
      go = 0;
      chk("scr/a1", txd, 8'hF6);
      @(posedge rxclk);
      #1;
      chk("scr/a2", txd, 8'h28);
      @(posedge rxclk);
      #1;
      chk("scr/p0", txd, 8'hFE);
      @(posedge rxclk);
      #1;
      chk("scr/p1", txd, 8'h04);
      repeat (16) @(posedge rxclk);
      #1;
      chk("scr/idle", txd, 8'h00);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
